// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard unit for the pipelined WISC core. A shift-register
//   scoreboard follows in-flight register writes from decode to writeback. A
//   countdown blocks issue for a fixed time after a control transfer issues.
//   Each cycle the unit decides whether the decode instruction issues or a NOP
//   bubble is injected, and it raises a one-cycle flush on redirect.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     id_valid            decode holds a real instruction
//     id_rs / id_rs_rd    source Rs and its read enable
//     id_rt / id_rt_rd    source Rt and its read enable
//     id_rd_rd            destination field read as a source (ST/STU), compared as id_rt
//     id_wr_en/id_wr_reg  register write enable and destination
//     id_is_load          instruction is a load
//     id_is_ctrl          instruction is a branch/jump
//     ex_redirect         control transfer resolved, fetch is redirected
//     issue_o             decode instruction advances this cycle
//     stall_o             hold fetch/decode, inject a NOP into execute
//     flush_o             squash fetch and decode this cycle
//     busy_regs           bit i set while any valid entry writes register i
//     ctrl_busy           control countdown is nonzero
//
//   Optional macro HAZARD_FWD_EN: execute/memory forwarding is present, so only
//   a load in the youngest entry (load-use) causes a stall. When the macro is
//   undefined the unit is a full interlock.
module hazard_scoreboard #(
   parameter int unsigned REG_W      = 3,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned CTRL_LAT   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_rs,
   input  logic                id_rs_rd,
   input  logic [REG_W-1:0]    id_rt,
   input  logic                id_rt_rd,
   input  logic                id_rd_rd,
   input  logic                id_wr_en,
   input  logic [REG_W-1:0]    id_wr_reg,
   input  logic                id_is_load,
   input  logic                id_is_ctrl,
   input  logic                ex_redirect,
   output logic                issue_o,
   output logic                stall_o,
   output logic                flush_o,
   output logic [NUM_REGS-1:0] busy_regs,
   output logic                ctrl_busy
);

   localparam int unsigned CNT_W = $clog2(CTRL_LAT + 1);

   // Entry 0 is the youngest; all entries shift toward PIPE_DEPTH-1 every cycle.
   logic [PIPE_DEPTH-1:0] r_valid;
   logic [PIPE_DEPTH-1:0] r_load;
   logic [REG_W-1:0]      r_reg [PIPE_DEPTH];
   logic [CNT_W-1:0]      r_ctrl_cnt;

   logic w_rt_used;
   logic w_raw_hit;
   logic w_unused_load;

   assign w_rt_used = id_rt_rd | id_rd_rd;

   // The load flag of the retiring entry is carried along but never consulted.
   assign w_unused_load = ^r_load;

   always_comb begin
      w_raw_hit = 1'b0;
`ifdef HAZARD_FWD_EN
      // Forwarding covers everything except a load that issued last cycle.
      if (r_valid[0] && r_load[0]) begin
         if (id_rs_rd && (id_rs == r_reg[0]))
            w_raw_hit = 1'b1;
         if (w_rt_used && (id_rt == r_reg[0]))
            w_raw_hit = 1'b1;
      end
`else
      // The oldest entry is excluded: the register file writes before it
      // reads, so the retiring value is already visible to decode.
      for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) begin
         if (r_valid[i]) begin
            if (id_rs_rd && (id_rs == r_reg[i]))
               w_raw_hit = 1'b1;
            if (w_rt_used && (id_rt == r_reg[i]))
               w_raw_hit = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      busy_regs = '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         for (int unsigned j = 0; j < NUM_REGS; j++) begin
            if (r_valid[i] && (r_reg[i] == REG_W'(j)))
               busy_regs[j] = 1'b1;
         end
      end
   end

   assign ctrl_busy = (r_ctrl_cnt != '0);
   assign flush_o   = ex_redirect;
   assign stall_o   = id_valid & ~ex_redirect & (w_raw_hit | ctrl_busy);
   assign issue_o   = id_valid & ~ex_redirect & ~stall_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         r_ctrl_cnt <= '0;
      end else begin
         // A stalled, squashed or absent instruction shifts in as a bubble.
         r_valid <= {r_valid[PIPE_DEPTH-2:0], issue_o & id_wr_en};
         if (ex_redirect)
            r_ctrl_cnt <= '0;
         else if (issue_o && id_is_ctrl)
            r_ctrl_cnt <= CNT_W'(CTRL_LAT);
         else if (r_ctrl_cnt != '0)
            r_ctrl_cnt <= r_ctrl_cnt - CNT_W'(1);
      end
   end

   // Payload is only meaningful alongside its valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      r_load   <= {r_load[PIPE_DEPTH-2:0], id_is_load};
      r_reg[0] <= id_wr_reg;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++)
         r_reg[i] <= r_reg[i-1];
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Bench for hazard_scoreboard. The reference model keeps, per register, the
//   cycle number of its most recent issued write, plus the last cycle in which
//   the control countdown is still active; hazards follow from instruction age.
module tb_hazard_scoreboard;

   localparam int REG_W    = 3;
   localparam int NUM_REGS = 8;
   localparam int PD       = 3;
   localparam int CL       = 4;

`ifdef HAZARD_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                id_valid;
   logic [REG_W-1:0]    id_rs;
   logic                id_rs_rd;
   logic [REG_W-1:0]    id_rt;
   logic                id_rt_rd;
   logic                id_rd_rd;
   logic                id_wr_en;
   logic [REG_W-1:0]    id_wr_reg;
   logic                id_is_load;
   logic                id_is_ctrl;
   logic                ex_redirect;
   logic                issue_o;
   logic                stall_o;
   logic                flush_o;
   logic [NUM_REGS-1:0] busy_regs;
   logic                ctrl_busy;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .REG_W      (REG_W),
      .NUM_REGS   (NUM_REGS),
      .PIPE_DEPTH (PD),
      .CTRL_LAT   (CL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rs_rd    (id_rs_rd),
      .id_rt       (id_rt),
      .id_rt_rd    (id_rt_rd),
      .id_rd_rd    (id_rd_rd),
      .id_wr_en    (id_wr_en),
      .id_wr_reg   (id_wr_reg),
      .id_is_load  (id_is_load),
      .id_is_ctrl  (id_is_ctrl),
      .ex_redirect (ex_redirect),
      .issue_o     (issue_o),
      .stall_o     (stall_o),
      .flush_o     (flush_o),
      .busy_regs   (busy_regs),
      .ctrl_busy   (ctrl_busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint cyc = 0;
   longint m_wr_t [NUM_REGS];
   bit     m_wr_ld [NUM_REGS];
   longint m_ctrl_end = 0;
   bit     model_ok = 1'b0;
   bit     e_issue  = 1'b0;

   function automatic bit reads_reg(input int r);
      return (id_rs_rd && (id_rs == REG_W'(r))) ||
             ((id_rt_rd || id_rd_rd) && (id_rt == REG_W'(r)));
   endfunction

   // Compare process: outputs checked against the model on every cycle.
   always @(negedge clk) begin
      if (model_ok) begin : cmp
         logic                hz;
         logic [NUM_REGS-1:0] bz;
         logic                cb;
         logic                st;
         logic                is;
         longint              age;
         hz = 1'b0;
         bz = '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            age = cyc - m_wr_t[r];
            if (age >= 1 && age <= PD)
               bz[r] = 1'b1;
            if (FWD != 0) begin
               if (age == 1 && m_wr_ld[r] && reads_reg(r))
                  hz = 1'b1;
            end else begin
               if (age >= 1 && age <= PD - 1 && reads_reg(r))
                  hz = 1'b1;
            end
         end
         cb = (cyc <= m_ctrl_end);
         st = id_valid && !ex_redirect && (hz || cb);
         is = id_valid && !ex_redirect && !st;
         e_issue <= is;
         chk("m_issue", issue_o, is);
         chk("m_stall", stall_o, st);
         chk("m_flush", flush_o, ex_redirect);
         chk("m_busy_regs", busy_regs, bz);
         chk("m_ctrl_busy", ctrl_busy, cb);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            m_wr_t[r] <= -1000;
         m_ctrl_end <= cyc;
         model_ok   <= 1'b1;
      end else if (model_ok) begin
         if (ex_redirect)
            m_ctrl_end <= cyc;
         else if (e_issue && id_is_ctrl)
            m_ctrl_end <= cyc + CL;
         if (e_issue && id_wr_en) begin
            m_wr_t[id_wr_reg]  <= cyc;
            m_wr_ld[id_wr_reg] <= id_is_load;
         end
      end
      cyc <= cyc + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      id_valid = 0; id_rs = '0; id_rs_rd = 0; id_rt = '0; id_rt_rd = 0;
      id_rd_rd = 0; id_wr_en = 0; id_wr_reg = '0; id_is_load = 0;
      id_is_ctrl = 0; ex_redirect = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drain();
      idle();
      for (int k = 0; k < PD + CL + 1; k++)
         tick();
   endtask

   // Hold the current decode inputs until issue_o rises; count stall cycles.
   task automatic hold_until_issue(input string name, input int exp_stalls);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         if (issue_o === 1'b1)
            done = 1'b1;
         else begin
            n++;
            @(posedge clk);
            #3;
         end
      end
      chk(name, n, exp_stalls);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
      settle();
      chk("rst_busy_regs", busy_regs, 0);
      chk("rst_ctrl_busy", ctrl_busy, 0);
      chk("rst_stall_idle", stall_o, 0);
      chk("rst_issue_idle", issue_o, 0);
      tick();

      // ADDI r3 <- r0, then ADD reads r3
      id_valid = 1; id_rs = 0; id_rs_rd = 1; id_wr_en = 1; id_wr_reg = 3;
      settle();
      chk("raw_writer_issue", issue_o, 1);
      tick();
      idle();
      id_valid = 1; id_rs = 3; id_rs_rd = 1; id_rt = 1; id_rt_rd = 1;
      id_wr_en = 1; id_wr_reg = 4;
      settle();
      chk("raw_busy_n1", busy_regs, 32'h08);
      chk("raw_stall_n1", stall_o, (FWD != 0) ? 0 : 1);
      hold_until_issue("raw_stall_cycles", (FWD != 0) ? 0 : 2);
      chk("raw_busy_at_issue", busy_regs[3], 1);
      tick();
      drain();

      // LD r2, then reader of r2 through Rt
      id_valid = 1; id_rs = 6; id_rs_rd = 1; id_wr_en = 1; id_wr_reg = 2; id_is_load = 1;
      settle();
      chk("lu_load_issue", issue_o, 1);
      tick();
      idle();
      id_valid = 1; id_rt = 2; id_rt_rd = 1;
      settle();
      chk("lu_stall_n1", stall_o, 1);
      hold_until_issue("lu_stall_cycles", (FWD != 0) ? 1 : 2);
      tick();
      drain();

      // Branch with no redirect
      id_valid = 1; id_is_ctrl = 1;
      settle();
      chk("br_issue", issue_o, 1);
      tick();
      idle();
      id_valid = 1; id_rs = 7; id_rs_rd = 1;
      settle();
      chk("br_ctrl_busy_n1", ctrl_busy, 1);
      chk("br_stall_n1", stall_o, 1);
      hold_until_issue("br_stall_cycles", CL);
      chk("br_ctrl_clear", ctrl_busy, 0);
      tick();
      drain();

      // Branch, then redirect two cycles later with a valid decode
      id_valid = 1; id_is_ctrl = 1;
      settle();
      chk("rd_br_issue", issue_o, 1);
      tick();
      idle();
      settle();
      chk("rd_idle_stall", stall_o, 0);
      chk("rd_idle_issue", issue_o, 0);
      chk("rd_idle_ctrl", ctrl_busy, 1);
      tick();
      id_valid = 1; id_rs = 0; id_rs_rd = 1; id_wr_en = 1; id_wr_reg = 4; ex_redirect = 1;
      settle();
      chk("rd_flush", flush_o, 1);
      chk("rd_issue", issue_o, 0);
      chk("rd_stall", stall_o, 0);
      tick();
      idle();
      id_valid = 1; id_rs = 4; id_rs_rd = 1;
      settle();
      chk("rd_ctrl_after", ctrl_busy, 0);
      chk("rd_no_entry", busy_regs, 0);
      chk("rd_reader_issue", issue_o, 1);
      tick();
      drain();

      // Writers to r1 in flight, then a one-cycle reset
      id_valid = 1; id_wr_en = 1; id_wr_reg = 1;
      tick();
      tick();
      idle();
      id_valid = 1; id_rs = 1; id_rs_rd = 1;
      rst = 1;
      tick();
      rst = 0;
      settle();
      chk("mrst_busy_regs", busy_regs, 0);
      chk("mrst_reader_issue", issue_o, 1);
      tick();
      drain();

      // Destination field read as source
      id_valid = 1; id_wr_en = 1; id_wr_reg = 5; id_is_load = 1;
      tick();
      idle();
      id_valid = 1; id_rt = 5; id_rd_rd = 1;
      settle();
      chk("rdrd_stall", stall_o, 1);
      id_rd_rd = 0;
      #1;
      chk("rdrd_noread_issue", issue_o, 1);
      tick();
      drain();

      // Mixed traffic checked by the model alone
      for (int k = 0; k < 400; k++) begin
         rst         = ($urandom_range(0, 63) == 0);
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs       = REG_W'($urandom_range(0, NUM_REGS - 1));
         id_rs_rd    = $urandom_range(0, 1) != 0;
         id_rt       = REG_W'($urandom_range(0, NUM_REGS - 1));
         id_rt_rd    = $urandom_range(0, 1) != 0;
         id_rd_rd    = ($urandom_range(0, 3) == 0);
         id_wr_en    = ($urandom_range(0, 3) != 0);
         id_wr_reg   = REG_W'($urandom_range(0, NUM_REGS - 1));
         id_is_load  = ($urandom_range(0, 2) == 0);
         id_is_ctrl  = ($urandom_range(0, 7) == 0);
         ex_redirect = ($urandom_range(0, 15) == 0);
         tick();
      end
      rst = 0;
      idle();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
